// File: rtl/gcm_tag_verifier.sv
// rtl/gcm_tag_verifier.sv - AES-GCM decrypt-side tag compare endpoint
// Pairs the computed tag (S ^ E(K,J0)) with the host's received tag and emits one pass/fail strobe per message.
module gcm_tag_verifier (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_tag_ready,
  input  logic [0:127] i_sblock,
  input  logic [0:127] i_encrypted_j0,
  input  logic         i_rx_tag_valid,
  output logic         o_rx_tag_ready,
  input  logic [0:127] i_rx_tag,
  input  logic [0:2]   i_tag_len,
  input  logic         i_abort,
  output logic         o_done,
  output logic         o_auth_ok,
  output logic         o_auth_fail,
  output logic         o_overrun,
  output logic         o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_RX,
    S_CMP,
    S_RESULT
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [0:127] tag_t;
  logic [0:127] tag_r;
  logic [0:2]   len_r;
  logic [0:127] mask;
  logic         len_bad;
  logic         comp_cap;
  logic         rx_cap;
  logic         mm_comb;

  // Abort suppresses both captures; the ready output itself is left as decoded.
  always_comb begin
    comp_cap  = i_tag_ready && !i_abort && (state == S_IDLE || state == S_RX);
    rx_cap    = i_rx_tag_valid && o_rx_tag_ready && !i_abort;
    state_nxt = state;
    if (i_abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (comp_cap && rx_cap) state_nxt = S_CMP;
          else if (comp_cap)      state_nxt = S_CALC;
          else if (rx_cap)        state_nxt = S_RX;
        end
        S_CALC:   if (rx_cap)   state_nxt = S_CMP;
        S_RX:     if (comp_cap) state_nxt = S_CMP;
        S_CMP:    state_nxt = S_RESULT;
        S_RESULT: state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Left-justified mask; the full-width reduction has no data-dependent exit.
  always_comb begin
    len_bad = (len_r > 3'd4);
    case (len_r)
      3'd1:    mask = {{120{1'b1}}, {8{1'b0}}};
      3'd2:    mask = {{112{1'b1}}, {16{1'b0}}};
      3'd3:    mask = {{104{1'b1}}, {24{1'b0}}};
      3'd4:    mask = {{96{1'b1}}, {32{1'b0}}};
      default: mask = {128{1'b1}};
    endcase
    mm_comb = (|((tag_t ^ tag_r) & mask)) | len_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      tag_t          <= '0;
      tag_r          <= '0;
      len_r          <= '0;
      o_rx_tag_ready <= 1'b0;
      o_done         <= 1'b0;
      o_auth_ok      <= 1'b0;
      o_auth_fail    <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      state          <= state_nxt;
      o_rx_tag_ready <= (state_nxt == S_IDLE) || (state_nxt == S_CALC);
      o_overrun      <= i_tag_ready && (state == S_CALC || state == S_CMP || state == S_RESULT);
      o_done         <= (state == S_CMP) && !i_abort;
      o_auth_ok      <= (state == S_CMP) && !i_abort && !mm_comb;
      o_auth_fail    <= (state == S_CMP) && !i_abort && mm_comb;
      // Returning to IDLE wipes both held tags so nothing leaks into the next message.
      if (state_nxt == S_IDLE) begin
        tag_t <= '0;
        tag_r <= '0;
        len_r <= '0;
      end else begin
        if (comp_cap) tag_t <= i_sblock ^ i_encrypted_j0;
        if (rx_cap) begin
          tag_r <= i_rx_tag;
          len_r <= i_tag_len;
        end
      end
    end
  end

  assign o_busy = (state != S_IDLE);

endmodule

// File: doc/gcm_tag_verifier.md
# gcm_tag_verifier

Decrypt-side authentication endpoint for the AES-GCM pipeline. It consumes the final GHASH block S and E(K,J0) from the last GHASH stage, and forms the computed tag T = S ^ E(K,J0). It accepts the received tag from the host through a valid/ready handshake, and compares the two over the negotiated tag length. It emits a single pass/fail result per message, so the control path can release or discard the buffered plaintext.

## Interface
- No parameters; datapath is fixed at 128 bits, bit 0 = MSB (first transmitted bit).
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_tag_ready` in 1: one-cycle strobe from the GHASH stage; `i_sblock` and `i_encrypted_j0` are valid. No backpressure.
- `i_sblock` in [0:127]: final GHASH accumulator S.
- `i_encrypted_j0` in [0:127]: E(K,J0) for the same message.
- `i_rx_tag_valid` in 1: received tag offered.
- `o_rx_tag_ready` out 1: block can accept a received tag.
- `i_rx_tag` in [0:127]: received tag, left-justified (bits [0:L-1] significant).
- `i_tag_len` in [0:2]: tag length code, sampled with `i_rx_tag`. Codes: 0=128, 1=120, 2=112, 3=104, 4=96 bits; codes 5–7 are invalid.
- `i_abort` in 1: synchronous flush of the current message.
- `o_done` out 1: one-cycle result strobe.
- `o_auth_ok` out 1: asserted only together with `o_done`; tags match.
- `o_auth_fail` out 1: asserted only together with `o_done`; mismatch or invalid length.
- `o_overrun` out 1: one-cycle pulse; a computed tag arrived while one was already held.
- `o_busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, CALC (computed tag held, waiting for rx), RX (rx tag held, waiting for computed), CMP, RESULT.
- Computed-tag capture:
  - Occurs when `i_tag_ready`=1 in IDLE or RX.
  - Register T = `i_sblock` ^ `i_encrypted_j0`.
- Rx-tag capture:
  - Occurs when `i_rx_tag_valid` & `o_rx_tag_ready`.
  - Register `i_rx_tag` and `i_tag_len`.
  - `o_rx_tag_ready` = 1 only in IDLE and CALC.
- Transitions:
  - IDLE: both captures in the same cycle → CMP; computed only → CALC; rx only → RX.
  - CALC: rx capture → CMP.
  - RX: computed capture → CMP.
  - CMP → RESULT (unconditional).
  - RESULT → IDLE (unconditional).
- CMP behaviour:
  - Mask M has bits [0:L-1] = 1, remainder 0.
  - mismatch = OR-reduce((T ^ R) & M), registered.
  - Invalid length code forces mismatch = 1.
  - The comparison is a full-width reduction with no early exit.
- RESULT: `o_done`=1, with `o_auth_ok`=~mismatch and `o_auth_fail`=mismatch.
- Overrun:
  - Condition: `i_tag_ready`=1 in CALC, CMP or RESULT.
  - The new value is dropped, the held T is unchanged, and `o_overrun` pulses the next cycle.
  - The in-flight comparison proceeds normally.
- Abort:
  - Highest priority; next state is IDLE and all held valid flags clear.
  - No `o_done` is issued; a RESULT pulse already being driven in that cycle still completes.
  - Captures presented in the same cycle as `i_abort` are ignored; `o_rx_tag_ready` stays as decoded, but the handshake is not consumed into state.
- Held tag registers are zeroed on return to IDLE, so no stale tag survives between messages.

## Timing
- Reset (`rst_n`=0): state=IDLE, all held registers=0.
- All outputs are 0 during reset, including `o_rx_tag_ready`.
- `o_rx_tag_ready` is registered and rises on the first clock edge after `rst_n` deasserts.
- Reset asserted mid-message (any state) discards everything; no `o_done` follows.
- Latency:
  - Last capture at edge E → CMP in cycle E+1 → `o_done` in cycle E+2 → IDLE in E+3.
  - A new rx tag is accepted in E+3 at the earliest.
- Throughput: one message per 3 cycles minimum (simultaneous arrival in IDLE).
- `o_overrun`, `o_done`, `o_auth_ok` and `o_auth_fail` are registered, single-cycle pulses.
- `o_auth_ok` and `o_auth_fail` are never high together.
- `o_busy` is decoded from the registered state.

## Test plan
- NIST GCM case 1 (K=0, no AAD/P):
  - Stimulus: S=0, EJ0=58e2fccefa7e3061367f1d57a4e7455a, rx tag identical, len=0, both presented the same cycle in IDLE.
  - Response: `o_done` and `o_auth_ok` high exactly 2 cycles after capture.
- Same vectors with rx tag bit 127 flipped:
  - len=0 → `o_auth_fail`.
  - len=4 (96-bit) → `o_auth_ok`, since the differing bit is outside the mask.
- Arrival order: rx tag 5 cycles before `i_tag_ready`, then the reverse order.
  - Both orders → pass.
  - `o_rx_tag_ready`=0 while in RX; `o_busy`=1 throughout.
- Overrun: second `i_tag_ready` with a different S while in CALC → `o_overrun` pulse 1 cycle later; result is computed from the first T.
- Invalid length: len=6 with matching tags → `o_auth_fail`.
- Interrupted messages:
  - `i_abort` in RX → IDLE, no `o_done`; the next full message passes.
  - `rst_n` low during CMP → all outputs 0; `o_rx_tag_ready` returns 1 cycle after release.
